mantissa_normalizer: RTL and testbench
======================================

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning significand width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: synchronous reset, active high.
REQ-006 SHALL have port In_Valid, input, 1 bit: the input word is valid.
REQ-007 SHALL have port In_Ready, output, 1 bit: the block accepts the input word this cycle.
REQ-008 SHALL have port Mant_In, input, MANT_W+1 bits: raw adder sum; the MSB is the carry-out.
REQ-009 SHALL have port Exp_In, input, EXP_W bits: pre-normalization exponent.
REQ-010 SHALL have port Sign_In, input, 1 bit: result sign, passed through.
REQ-011 SHALL have port Out_Valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port Out_Ready, input, 1 bit: the downstream block accepts the result.
REQ-013 SHALL have port Mant_Out, output, MANT_W bits: normalized significand, with MSB = 1 unless the result is zero.
REQ-014 SHALL have port Exp_Out, output, EXP_W bits: adjusted exponent.
REQ-015 SHALL have port Sign_Out, output, 1 bit: registered Sign_In.
REQ-016 SHALL have ports Zero, Underflow and Overflow, outputs, 1 bit each: result flags.

Function
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers the carry bit and the leading-zero count (LZC, 0..MANT_W) of Mant_In[MANT_W-1:0]; stage 2 registers the shifted and adjusted result.
REQ-018 SHALL have a latency of exactly 2 cycles from input acceptance to Out_Valid when Out_Ready stays high, with throughput of 1 word per cycle.
REQ-019 SHALL accept an input when In_Valid && In_Ready, and complete an output transfer when Out_Valid && Out_Ready.
REQ-020 SHALL advance stage 2 when !v2 || Out_Ready, and advance stage 1 when !v1 || stage 2 advances; In_Ready = !v1 || stage-2 advance, with no lost or duplicated words.
REQ-021 SHALL hold Mant_Out, Exp_Out, Sign_Out and all flags stable while Out_Valid && !Out_Ready.
REQ-022 SHALL handle carry = 1 as follows: Mant_Out = Mant_In[MANT_W:1] (truncating right shift by 1), Exp_Out = Exp_In+1.
REQ-023 SHALL, on carry = 1 with Exp_In+1 >= 2^EXP_W-1, set Overflow = 1, Exp_Out = all ones and Mant_Out = 0.
REQ-024 SHALL handle carry = 0 with a nonzero low field as follows: left-shift by LZC with zero fill, Exp_Out = Exp_In-LZC.
REQ-025 SHALL, on carry = 0 with LZC >= Exp_In, flush to zero: Underflow = 1, Mant_Out = 0, Exp_Out = 0.
REQ-026 SHALL, when Mant_In = 0, set Zero = 1, Mant_Out = 0 and Exp_Out = 0, with Underflow = 0.
REQ-027 SHALL assert at most one of Zero, Underflow and Overflow per result; all flags are 0 for a normal result.
REQ-028 SHALL pass Mant_In[MANT_W-1:0] unchanged with Exp_Out = Exp_In when LZC = 0 and carry = 0.
REQ-029 SHALL perform all exponent arithmetic at EXP_W+1 bits so that the wrap comparisons in REQ-023 and REQ-025 are exact.

Reset
REQ-030 SHALL, while Rst is sampled high, clear v1 and v2, and drive Out_Valid = 0, In_Ready = 0, and Mant_Out, Exp_Out, Sign_Out and all flags to 0.
REQ-031 SHALL discard in-flight words on reset mid-operation, with Out_Valid = 0 from the cycle after Rst is sampled.
REQ-032 SHALL raise In_Ready in the first cycle after Rst deasserts.

Structure
REQ-033 SHALL take MANT_W, EXP_W, EXP_MAX (2^EXP_W-1) and LZC_W (clog2(MANT_W+1)) from the shared package fp_pkg.
REQ-034 SHALL instantiate one sub-module, left_barrel_shifter: a MANT_W-bit, LZC_W-stage logarithmic left shifter with zero fill, the mirror of the alignment right shifter.
REQ-035 SHALL implement the LZC as combinational logic inside stage 1, with no other sub-modules.

Verification
REQ-036 SHALL cover: Mant_In = 0x0800000, Exp_In = 100 -> after 2 cycles Mant_Out = 0x800000, Exp_Out = 100, all flags 0.
REQ-037 SHALL cover: Mant_In = 0x1800000, Exp_In = 100 -> Mant_Out = 0xC00000, Exp_Out = 101; with Exp_In = 254 -> Overflow = 1, Exp_Out = 255, Mant_Out = 0.
REQ-038 SHALL cover: Mant_In = 0x0000001, Exp_In = 30 -> Mant_Out = 0x800000, Exp_Out = 7; with Exp_In = 23 -> Underflow = 1, outputs 0.
REQ-039 SHALL cover: Mant_In = 0 -> Zero = 1, Exp_Out = 0, Mant_Out = 0.
REQ-040 SHALL cover: 6 back-to-back inputs with Out_Ready held low for cycles 3-5 -> outputs in order, none lost or duplicated, outputs stable while stalled, In_Ready low once both stages are full.
REQ-041 SHALL cover: Rst pulsed with 2 words in flight -> Out_Valid = 0 the next cycle, neither word ever emitted, and a new input emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point datapath widths and result flag type
package fp_pkg;

   localparam int MANT_W  = 24;
   localparam int EXP_W   = 8;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam int LZC_W   = $clog2(MANT_W + 1);

   typedef struct packed {
      logic zero;
      logic underflow;
      logic overflow;
   } flags_t;

endpackage

// File: rtl/left_barrel_shifter.sv
// rtl/left_barrel_shifter.sv - logarithmic left shifter with zero fill
module left_barrel_shifter #(
   parameter int W   = 24,
   parameter int S_W = 5
) (
   input  logic [W-1:0]   data,
   input  logic [S_W-1:0] amt,
   output logic [W-1:0]   result
);

   logic [W-1:0] stg [S_W+1];

   assign stg[0] = data;

   for (genvar i = 0; i < S_W; i++) begin : g_stage
      assign stg[i+1] = amt[i] ? (stg[i] << (2 ** i)) : stg[i];
   end

   assign result = stg[S_W];

endmodule

// File: rtl/mantissa_normalizer.sv
// rtl/mantissa_normalizer.sv - two-stage post-add normalizer with valid/ready flow control
module mantissa_normalizer
   import fp_pkg::*;
#(
   parameter int MANT_W = fp_pkg::MANT_W,
   parameter int EXP_W  = fp_pkg::EXP_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [MANT_W:0]   Mant_In,
   input  logic [EXP_W-1:0]  Exp_In,
   input  logic              Sign_In,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [MANT_W-1:0] Mant_Out,
   output logic [EXP_W-1:0]  Exp_Out,
   output logic              Sign_Out,
   output logic              Zero,
   output logic              Underflow,
   output logic              Overflow
);

   localparam int LZC_BITS = $clog2(MANT_W + 1);
   localparam int XW       = EXP_W + 1;
   localparam logic [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

   logic                v1, v2, adv1, adv2;
   logic                c1, s1;
   logic [LZC_BITS-1:0] lzc_d, lzc1;
   logic [MANT_W-1:0]   low1, shifted, m_d;
   logic [EXP_W-1:0]    exp1, e_d;
   logic [XW-1:0]       e_inc;
   flags_t              f_d;

   assign adv2      = !v2 || Out_Ready;
   assign adv1      = !v1 || adv2;
   assign In_Ready  = !Rst && adv1;
   assign Out_Valid = v2;

   // Highest set bit wins; an all-zero field reports MANT_W.
   always_comb begin
      lzc_d = LZC_BITS'(MANT_W);
      for (int i = 0; i < MANT_W; i++) begin
         if (Mant_In[i]) lzc_d = LZC_BITS'(MANT_W - 1 - i);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         v1   <= 1'b0;
         c1   <= 1'b0;
         lzc1 <= '0;
         low1 <= '0;
         exp1 <= '0;
         s1   <= 1'b0;
      end else if (adv1) begin
         v1   <= In_Valid;
         c1   <= Mant_In[MANT_W];
         lzc1 <= lzc_d;
         low1 <= Mant_In[MANT_W-1:0];
         exp1 <= Exp_In;
         s1   <= Sign_In;
      end
   end

   left_barrel_shifter #(.W(MANT_W), .S_W(LZC_BITS)) u_shift (
      .data   (low1),
      .amt    (lzc1),
      .result (shifted)
   );

   // Exponent compares are one bit wider so Exp_In+1 cannot wrap past the limit.
   assign e_inc = XW'(exp1) + XW'(1);

   always_comb begin
      m_d = '0;
      e_d = '0;
      f_d = '0;
      if (c1) begin
         if (e_inc >= EXP_TOP) begin
            f_d.overflow = 1'b1;
            e_d          = '1;
         end else begin
            m_d = {1'b1, low1[MANT_W-1:1]};
            e_d = e_inc[EXP_W-1:0];
         end
      end else if (lzc1 == LZC_BITS'(MANT_W)) begin
         f_d.zero = 1'b1;
      end else if (XW'(lzc1) >= XW'(exp1)) begin
         f_d.underflow = 1'b1;
      end else begin
         m_d = shifted;
         e_d = exp1 - EXP_W'(lzc1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         v2        <= 1'b0;
         Mant_Out  <= '0;
         Exp_Out   <= '0;
         Sign_Out  <= 1'b0;
         Zero      <= 1'b0;
         Underflow <= 1'b0;
         Overflow  <= 1'b0;
      end else if (adv2) begin
         v2        <= v1;
         Mant_Out  <= m_d;
         Exp_Out   <= e_d;
         Sign_Out  <= s1;
         Zero      <= f_d.zero;
         Underflow <= f_d.underflow;
         Overflow  <= f_d.overflow;
      end
   end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb/tb_mantissa_normalizer.sv - randomized and directed bench against an arithmetic reference model
module tb_mantissa_normalizer;

   localparam int MW = 24;
   localparam int EW = 8;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          In_Valid = 1'b0;
   logic          In_Ready;
   logic [MW:0]   Mant_In = '0;
   logic [EW-1:0] Exp_In = '0;
   logic          Sign_In = 1'b0;
   logic          Out_Valid;
   logic          Out_Ready = 1'b1;
   logic [MW-1:0] Mant_Out;
   logic [EW-1:0] Exp_Out;
   logic          Sign_Out, Zero, Underflow, Overflow;

   always #5 Clk = ~Clk;

   mantissa_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .Mant_In   (Mant_In),
      .Exp_In    (Exp_In),
      .Sign_In   (Sign_In),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Mant_Out  (Mant_Out),
      .Exp_Out   (Exp_Out),
      .Sign_Out  (Sign_Out),
      .Zero      (Zero),
      .Underflow (Underflow),
      .Overflow  (Overflow)
   );

   typedef struct packed {
      logic [MW-1:0] m;
      logic [EW-1:0] e;
      logic          s, z, u, o;
   } res_t;

   typedef struct {
      res_t r;
      int   acc;
      bit   stalled;
      bit   seen;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   prev_rst = 1'b0;

   always @(posedge Clk) cyc++;

   function automatic res_t mk(int m, int e, bit s, bit z, bit u, bit o);
      res_t r;
      r.m = MW'(m); r.e = EW'(e); r.s = s; r.z = z; r.u = u; r.o = o;
      return r;
   endfunction

   // Plain integer arithmetic on the value: halve on carry, else scale up to the top bit.
   function automatic res_t model(logic [MW:0] mant, logic [EW-1:0] exp, logic sign);
      res_t r;
      int   mi, e, n;
      r = '0;
      r.s = sign;
      mi = int'(mant);
      e  = int'(exp);
      if (mi == 0) begin
         r.z = 1'b1;
      end else if (mi >= (1 << MW)) begin
         if (e + 1 >= (1 << EW) - 1) begin
            r.o = 1'b1;
            r.e = '1;
         end else begin
            r.m = MW'(mi / 2);
            r.e = EW'(e + 1);
         end
      end else begin
         n = 0;
         while (mi < (1 << (MW - 1 - n))) n++;
         if (n >= e) r.u = 1'b1;
         else begin
            r.m = MW'(mi * (1 << n));
            r.e = EW'(e - n);
         end
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   always @(negedge Clk) begin
      ent_t h;
      if (prev_rst) begin
         chk("reset_out_valid", 64'(Out_Valid), 64'd0);
         chk("reset_outputs", 64'({Mant_Out, Exp_Out, Sign_Out, Zero, Underflow, Overflow}), 64'd0);
      end
      if (Rst) begin
         chk("in_ready_in_reset", 64'(In_Ready), 64'd0);
         q.delete();
      end else begin
         chk("in_ready", 64'(In_Ready), 64'((q.size() < 2) || Out_Ready));
         if (q.size() == 0) begin
            chk("spurious_valid", 64'(Out_Valid), 64'd0);
         end else if (Out_Valid) begin
            h = q[0];
            if (!h.seen) begin
               h.seen = 1'b1;
               if (!h.stalled) chk("latency", 64'(cyc - h.acc), 64'd2);
               q[0] = h;
            end
            chk("result", 64'({Mant_Out, Exp_Out, Sign_Out, Zero, Underflow, Overflow}), 64'(q[0].r));
            if (Out_Ready) void'(q.pop_front());
         end
         if (!Out_Ready) begin
            foreach (q[i]) begin
               h = q[i];
               h.stalled = 1'b1;
               q[i] = h;
            end
         end
         if (In_Valid && In_Ready) begin
            h.r = model(Mant_In, Exp_In, Sign_In);
            h.acc = cyc;
            h.stalled = 1'b0;
            h.seen = 1'b0;
            q.push_back(h);
         end
      end
      prev_rst = Rst;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(logic [MW:0] m, logic [EW-1:0] e, logic s);
      bit acc;
      acc = 1'b0;
      Mant_In = m; Exp_In = e; Sign_In = s; In_Valid = 1'b1;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge Clk);
         acc = In_Ready;
         tick();
      end
      In_Valid = 1'b0;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && q.size() != 0; t++) tick();
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   logic [MW:0]   rm;
   logic [EW-1:0] re;
   bit            acc_r, seen_low;
   int            sent;

   initial begin
      repeat (3) tick();
      Rst = 1'b0;

      chk("model_pass", 64'(model(25'h0800000, 8'd100, 1'b0)), 64'(mk(24'h800000, 100, 0, 0, 0, 0)));
      chk("model_carry", 64'(model(25'h1800000, 8'd100, 1'b1)), 64'(mk(24'hC00000, 101, 1, 0, 0, 0)));
      chk("model_ovf", 64'(model(25'h1800000, 8'd254, 1'b0)), 64'(mk(0, 255, 0, 0, 0, 1)));
      chk("model_shift", 64'(model(25'h0000001, 8'd30, 1'b0)), 64'(mk(24'h800000, 7, 0, 0, 0, 0)));
      chk("model_unf", 64'(model(25'h0000001, 8'd23, 1'b0)), 64'(mk(0, 0, 0, 0, 1, 0)));
      chk("model_zero", 64'(model(25'h0000000, 8'd77, 1'b1)), 64'(mk(0, 0, 1, 1, 0, 0)));

      send(25'h0800000, 8'd100, 1'b0); tick();
      send(25'h1800000, 8'd100, 1'b1); tick();
      send(25'h1800000, 8'd254, 1'b0); tick();
      send(25'h0000001, 8'd30, 1'b0);  tick();
      send(25'h0000001, 8'd23, 1'b1);  tick();
      send(25'h0000000, 8'd77, 1'b1);
      drain();

      // Six back-to-back words with the consumer stalled for cycles 3-5.
      sent = 0; seen_low = 1'b0;
      rm = {1'b0, 24'($urandom)}; re = EW'($urandom_range(40, 200));
      for (int k = 0; k < 40 && sent < 6; k++) begin
         Out_Ready = !(k >= 3 && k <= 5);
         In_Valid = 1'b1; Mant_In = rm; Exp_In = re; Sign_In = k[0];
         @(negedge Clk);
         acc_r = In_Ready;
         if (!In_Ready) seen_low = 1'b1;
         tick();
         if (acc_r) begin
            sent++;
            rm = {1'($urandom_range(0, 1)), 24'($urandom) >> $urandom_range(0, 5)};
            re = EW'($urandom_range(40, 200));
         end
      end
      In_Valid = 1'b0; Out_Ready = 1'b1;
      chk("stall_sent_all", 64'(sent), 64'd6);
      chk("stall_backpressure", 64'(seen_low), 64'd1);
      drain();

      // Reset with two words in flight; neither may appear afterwards.
      In_Valid = 1'b1; Mant_In = 25'h0400000; Exp_In = 8'd90; tick();
      Mant_In = 25'h0200000; Exp_In = 8'd91; tick();
      In_Valid = 1'b0; Out_Ready = 1'b0; Rst = 1'b1; tick();
      Rst = 1'b0; Out_Ready = 1'b1;
      repeat (8) tick();
      send(25'h0123456, 8'd60, 1'b1);
      drain();

      In_Valid = 1'b0;
      for (int k = 0; k < 800; k++) begin
         if (!In_Valid || acc_r) begin
            In_Valid = ($urandom_range(0, 3) != 0);
            Mant_In = {1'($urandom_range(0, 3) == 0), 24'($urandom) >> $urandom_range(0, 25)};
            case ($urandom_range(0, 3))
               0:       Exp_In = EW'($urandom_range(0, 30));
               1:       Exp_In = EW'($urandom_range(250, 255));
               default: Exp_In = EW'($urandom);
            endcase
            Sign_In = 1'($urandom);
         end
         Out_Ready = ($urandom_range(0, 3) != 0);
         Rst = (k == 400);
         @(negedge Clk);
         acc_r = In_Valid && In_Ready;
         tick();
      end
      In_Valid = 1'b0; Out_Ready = 1'b1; Rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
